// File: rtl/jb_cordic_pkg.sv
// Shared constants and types for the CORDIC vectoring engine that turns {Q,I} samples back into NCO phase.
package jb_cordic_pkg;

  localparam int ATAN_ENTRIES = 32;

  // CORDIC gain for many iterations, 1.64676 in Q16.
  localparam int CORDIC_GAIN_Q16 = 107922;

  // atan(2^-i) on a grid where a quarter turn is 2^30.
  localparam logic [31:0] ATAN_TBL [ATAN_ENTRIES] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } cordic_state_t;

  // Rescale a table entry to a full turn of 2^phase_width with round-half-up.
  function automatic logic [31:0] atan_scaled(input logic [4:0] idx, input int phase_width);
    int sh;
    logic [32:0] v;
    sh = 32 - phase_width;
    if (sh <= 0) begin
      return ATAN_TBL[idx];
    end
    v = {1'b0, ATAN_TBL[idx]} + (33'd1 << (sh - 1));
    return 32'(v >> sh);
  endfunction

endpackage

// File: rtl/jb_cordic_vec_stage.sv
// One CORDIC vectoring micro-rotation: drives y toward zero and accumulates the rotated angle in z.
module jb_cordic_vec_stage
  import jb_cordic_pkg::*;
#(
  parameter int XW          = 18,
  parameter int PHASE_WIDTH = 16
) (
  input  logic signed [XW-1:0]          x,
  input  logic signed [XW-1:0]          y,
  input  logic signed [PHASE_WIDTH-1:0] z,
  input  logic [4:0]                    i,
  output logic signed [XW-1:0]          x_next,
  output logic signed [XW-1:0]          y_next,
  output logic signed [PHASE_WIDTH-1:0] z_next
);

  logic signed [XW-1:0]          x_sh;
  logic signed [XW-1:0]          y_sh;
  logic signed [PHASE_WIDTH-1:0] atan_i;

  assign x_sh   = x >>> i;
  assign y_sh   = y >>> i;
  assign atan_i = $signed(PHASE_WIDTH'(atan_scaled(i, PHASE_WIDTH)));

  always_comb begin
    if (!y[XW-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_i;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_i;
    end
  end

endmodule

// File: rtl/jb_iq2phase.sv
// Inverse quarter-wave NCO: folds a {Q,I} sample into the first quadrant, then runs iterative CORDIC vectoring for phase and magnitude.
module jb_iq2phase
  import jb_cordic_pkg::*;
#(
  parameter int PRECISION   = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int ITER        = 14
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [2*PRECISION-1:0]   in_iq,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PHASE_WIDTH-1:0]   out_phase,
  output logic [PRECISION:0]       out_mag,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int         XW        = PRECISION + 2;
  localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

  cordic_state_t                 state;
  logic signed [XW-1:0]          i_ext;
  logic signed [XW-1:0]          q_ext;
  logic signed [XW-1:0]          x_fold;
  logic signed [XW-1:0]          y_fold;
  logic [1:0]                    quad_fold;
  logic                          i_neg, i_zero, q_neg, q_zero;
  logic signed [XW-1:0]          x_r, y_r, x_nx, y_nx;
  logic signed [PHASE_WIDTH-1:0] z_r, z_nx;
  logic [1:0]                    quad;
  logic [4:0]                    iter_cnt;
  logic                          zero_r;
  logic [PHASE_WIDTH-1:0]        phase_sum;

  // Widen by two bits before negating so -2^(PRECISION-1) and the CORDIC growth both fit.
  assign i_ext  = {{2{in_iq[PRECISION-1]}}, in_iq[PRECISION-1:0]};
  assign q_ext  = {{2{in_iq[2*PRECISION-1]}}, in_iq[2*PRECISION-1:PRECISION]};
  assign i_neg  = i_ext[XW-1];
  assign q_neg  = q_ext[XW-1];
  assign i_zero = (i_ext == '0);
  assign q_zero = (q_ext == '0);

  always_comb begin
    quad_fold = 2'd0;
    x_fold    = i_ext;
    y_fold    = q_ext;
    if (q_neg && !i_neg) begin
      quad_fold = 2'd3;
      x_fold    = -q_ext;
      y_fold    = i_ext;
    end else if (i_neg && (q_neg || q_zero)) begin
      quad_fold = 2'd2;
      x_fold    = -i_ext;
      y_fold    = -q_ext;
    end else if ((i_neg || i_zero) && !q_neg && !q_zero) begin
      quad_fold = 2'd1;
      x_fold    = q_ext;
      y_fold    = -i_ext;
    end
  end

  jb_cordic_vec_stage #(
    .XW          (XW),
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_stage (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .i      (iter_cnt),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  // Quadrant supplies the top two phase bits; a slightly negative z wraps below a full turn.
  assign phase_sum = {quad, {(PHASE_WIDTH-2){1'b0}}} + z_nx;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_phase <= '0;
      out_mag   <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      quad      <= '0;
      iter_cnt  <= '0;
      zero_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r      <= x_fold;
            y_r      <= y_fold;
            z_r      <= '0;
            quad     <= quad_fold;
            zero_r   <= i_zero && q_zero;
            iter_cnt <= '0;
            in_ready <= 1'b0;
            state    <= ROT;
          end
        end
        ROT: begin
          x_r      <= x_nx;
          y_r      <= y_nx;
          z_r      <= z_nx;
          iter_cnt <= iter_cnt + 5'd1;
          // A zero vector would otherwise accumulate every positive micro-angle.
          if (iter_cnt == LAST_ITER) begin
            out_phase <= zero_r ? '0 : phase_sum;
            out_mag   <= x_nx[PRECISION:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jb_iq2phase.sv
// Directed-vector bench for jb_iq2phase; an atan2/sqrt reference model checks every delivered result.
`timescale 1ns/1ps
module tb_jb_iq2phase;

  localparam int  PRECISION   = 16;
  localparam int  PHASE_WIDTH = 16;
  localparam int  ITER        = 14;
  localparam int  TURN        = 1 << PHASE_WIDTH;
  localparam real PI          = 3.14159265358979323846;

  logic                   clk       = 1'b0;
  logic                   resetn    = 1'b0;
  logic [2*PRECISION-1:0] in_iq     = '0;
  logic                   in_valid  = 1'b0;
  logic                   out_ready = 1'b1;
  logic                   in_ready;
  logic [PHASE_WIDTH-1:0] out_phase;
  logic [PRECISION:0]     out_mag;
  logic                   out_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int phase;
    int mag;
    int due;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_pop;
  logic prev_valid = 1'b0;
  int   held_phase = 0;
  int   held_mag   = 0;

  jb_iq2phase #(
    .PRECISION   (PRECISION),
    .PHASE_WIDTH (PHASE_WIDTH),
    .ITER        (ITER)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_iq     (in_iq),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_phase (out_phase),
    .out_mag   (out_mag),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wrap(input int x);
    return ((x % TURN) + TURN) % TURN;
  endfunction

  // Ideal answer: angle of the vector on a full-turn grid, magnitude times the ITER-stage gain.
  function automatic exp_t model(input int iv, input int qv, input int due);
    exp_t r;
    real  a;
    real  k;
    r.due = due;
    if (iv == 0 && qv == 0) begin
      r.phase = 0;
      r.mag   = 0;
      return r;
    end
    k = 1.0;
    for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    a       = $atan2(real'(qv), real'(iv));
    r.phase = wrap(int'($floor(a * TURN / (2.0 * PI) + 0.5)));
    r.mag   = int'($floor(k * $sqrt(real'(iv) * real'(iv) + real'(qv) * real'(qv)) + 0.5));
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int want, input int tol, input bit circ);
    int d;
    d = act - want;
    if (circ) d = ((d % TURN) + TURN + TURN / 2) % TURN - TURN / 2;
    n_vec++;
    if (d > tol || d < -tol) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, act, want, tol);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveSample(input int iv, input int qv);
    int n;
    n = 0;
    while (!in_ready && n < 64) begin
      waitCycles(1);
      n++;
    end
    checkOutput("accept_timeout", int'(in_ready), 1, 0, 0);
    in_iq    = {qv[PRECISION-1:0], iv[PRECISION-1:0]};
    in_valid = 1'b1;
    waitCycles(1);
    in_valid = 1'b0;
  endtask

  task automatic waitResult();
    int n;
    n = 0;
    while (!out_valid && n < 64) begin
      waitCycles(1);
      n++;
    end
    checkOutput("result_timeout", int'(out_valid), 1, 0, 0);
  endtask

  task automatic applyStimulus(input int iv, input int qv, output int ph, output int mg);
    driveSample(iv, qv);
    waitResult();
    ph = int'(out_phase);
    mg = int'(out_mag);
    waitCycles(1);
  endtask

  // Compare process: handshake rules, latency, hold stability and model agreement on every cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      checkOutput("in_ready", int'(in_ready), (exp_q.size() == 0) ? 1 : 0, 0, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_valid", int'(out_valid), 0, 0, 0);
        end else begin
          if (!prev_valid) checkOutput("latency", cyc, exp_q[0].due, 0, 0);
          else begin
            checkOutput("hold_phase", int'(out_phase), held_phase, 0, 0);
            checkOutput("hold_mag", int'(out_mag), held_mag, 0, 0);
          end
          if (out_ready) begin
            e_pop = exp_q.pop_front();
            checkOutput("model_phase", int'(out_phase), e_pop.phase, 3, 1);
            checkOutput("model_mag", int'(out_mag), e_pop.mag, 10, 0);
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(int'($signed(in_iq[PRECISION-1:0])),
                              int'($signed(in_iq[2*PRECISION-1:PRECISION])), cyc + ITER + 1));
    end
    prev_valid = out_valid;
    held_phase = int'(out_phase);
    held_mag   = int'(out_mag);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ph;
    int mg;
    int p;
    real ang;

    resetn = 1'b0;
    waitCycles(3);
    resetn = 1'b1;
    waitCycles(1);
    checkOutput("reset_out_valid", int'(out_valid), 0, 0, 0);
    checkOutput("reset_out_phase", int'(out_phase), 0, 0, 0);
    checkOutput("reset_out_mag", int'(out_mag), 0, 0, 0);
    checkOutput("reset_in_ready", int'(in_ready), 1, 0, 0);

    applyStimulus(16384, 0, ph, mg);
    checkOutput("pos_i_phase", ph, 0, 2, 1);
    checkOutput("pos_i_mag", mg, 26981, 4, 0);
    applyStimulus(0, 16384, ph, mg);
    checkOutput("pos_q_phase", ph, 16384, 2, 1);
    applyStimulus(-16384, 0, ph, mg);
    checkOutput("neg_i_phase", ph, 32768, 2, 1);
    applyStimulus(0, -16384, ph, mg);
    checkOutput("neg_q_phase", ph, 49152, 2, 1);
    applyStimulus(11585, 11585, ph, mg);
    checkOutput("diag_phase", ph, 8192, 2, 1);
    applyStimulus(-32768, -32768, ph, mg);
    checkOutput("corner_phase", ph, 40960, 2, 1);
    checkOutput("corner_mag", mg, 76315, 8, 0);

    applyStimulus(30000, -5000, ph, mg);
    applyStimulus(-1234, 20000, ph, mg);
    applyStimulus(-20000, -9000, ph, mg);
    applyStimulus(-32768, 0, ph, mg);
    applyStimulus(32767, -32768, ph, mg);

    // Backpressure: result must hold while a stray sample is offered and ignored.
    out_ready = 1'b0;
    driveSample(10000, 20000);
    waitResult();
    for (int c = 0; c < 5; c++) begin
      in_iq    = {16'sd5000, -16'sd7000};
      in_valid = (c == 2);
      waitCycles(1);
      checkOutput("bp_in_ready", int'(in_ready), 0, 0, 0);
      checkOutput("bp_out_valid", int'(out_valid), 1, 0, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitCycles(1);
    checkOutput("bp_release_ready", int'(in_ready), 1, 0, 0);
    checkOutput("bp_release_valid", int'(out_valid), 0, 0, 0);

    // Reset during iteration 5 must discard the sample entirely.
    driveSample(20000, 7000);
    waitCycles(5);
    resetn = 1'b0;
    waitCycles(1);
    resetn = 1'b1;
    waitCycles(1);
    checkOutput("midrst_out_valid", int'(out_valid), 0, 0, 0);
    checkOutput("midrst_out_phase", int'(out_phase), 0, 0, 0);
    checkOutput("midrst_out_mag", int'(out_mag), 0, 0, 0);
    checkOutput("midrst_in_ready", int'(in_ready), 1, 0, 0);
    waitCycles(ITER + 4);
    checkOutput("midrst_no_output", int'(out_valid), 0, 0, 0);
    applyStimulus(0, 0, ph, mg);
    checkOutput("zero_phase", ph, 0, 0, 0);
    checkOutput("zero_mag", mg, 0, 0, 0);

    // Loopback sweep: samples synthesised from a known NCO phase must map back to it.
    for (int k = 0; k < 16; k++) begin
      p   = wrap(k * 4096 + 777);
      ang = 2.0 * PI * real'(p) / real'(TURN);
      applyStimulus(int'(30000.0 * $cos(ang)), int'(30000.0 * $sin(ang)), ph, mg);
      checkOutput("nco_track", ph, p, 3, 1);
    end

    waitCycles(4);
    checkOutput("drain", exp_q.size(), 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
